// File: rtl/wb_cmd_master_if.sv
// ---------------------------------------------------------------------------
// wb_cmd_master_if
//   Bundles the local command/response port and the Wishbone initiator bus
//   of wb_cmd_master.
//   master modport : the wb_cmd_master side
//                    (takes commands, issues Wishbone cycles, returns responses)
//   slave modport  : the environment side
//                    (command source, response sink and Wishbone target)
//   Command : cmd_valid_i, cmd_ready_o, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i
//   Response: rsp_valid_o, rsp_dat_o, rsp_status_o
//   Wishbone: wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
//             wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
// ---------------------------------------------------------------------------
interface wb_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_we_i;
  logic [ADDR_WIDTH-1:0] cmd_adr_i;
  logic [DATA_WIDTH-1:0] cmd_dat_i;
  logic [SEL_WIDTH-1:0]  cmd_sel_i;

  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_dat_o;
  logic [1:0]            rsp_status_o;

  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [SEL_WIDTH-1:0]  wb_sel_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  logic                  wb_rty_i;
  logic                  wb_stall_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_status_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//   Wishbone classic-pipelined initiator. Each accepted local command becomes
//   one Wishbone transaction (possibly re-issued on rty), and produces exactly
//   one single-cycle response carrying read data and a status code:
//     00 ok, 01 err, 10 timeout, 11 retry exhausted.
//   Ports:
//     clk_i  : clock
//     rst_i  : asynchronous reset, active-high
//     bus    : wb_cmd_master_if.master (command, response and Wishbone signals)
//   All outputs are registered except cmd_ready_o, which is high in IDLE.
// ---------------------------------------------------------------------------
module wb_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_cmd_master_if.master    bus
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);
  // Value of the attempt counter during the last cycle an attempt may live.
  localparam logic [15:0]   TMO_LAST    = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [15:0]           tmo_q, tmo_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic [1:0]            rsp_status_q, rsp_status_d;

  logic resp_seen;
  logic expired;

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;

    // A response only counts once the strobe has been taken: in WAIT, or in
    // REQ during the cycle the slave is not stalling (zero-wait slave).
    resp_seen = ((state_q == WAIT) || ((state_q == REQ) && !bus.wb_stall_i)) &&
                (bus.wb_ack_i || bus.wb_err_i || bus.wb_rty_i);
    expired   = (tmo_q == TMO_LAST);

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          we_d    = bus.cmd_we_i;
          adr_d   = bus.cmd_adr_i;
          dat_d   = bus.cmd_dat_i;
          sel_d   = bus.cmd_sel_i;
          retry_d = '0;
          tmo_d   = '0;
          state_d = REQ;
        end
      end
      REQ, WAIT: begin
        tmo_d = tmo_q + 16'd1;
        if (resp_seen) begin
          // err outranks rty, which outranks ack.
          if (bus.wb_err_i) begin
            rsp_status_d = 2'b01;
            rsp_dat_d    = '0;
            state_d      = RSP;
          end else if (bus.wb_rty_i) begin
            if (retry_q < MAX_RETRY_C) begin
              retry_d = retry_q + RW'(1);
              tmo_d   = '0;
              state_d = REQ;
            end else begin
              rsp_status_d = 2'b11;
              rsp_dat_d    = '0;
              state_d      = RSP;
            end
          end else begin
            rsp_status_d = 2'b00;
            rsp_dat_d    = we_q ? '0 : bus.wb_dat_i;
            state_d      = RSP;
          end
        end else if (expired) begin
          rsp_status_d = 2'b10;
          rsp_dat_d    = '0;
          state_d      = RSP;
        end else if ((state_q == REQ) && !bus.wb_stall_i) begin
          state_d = WAIT;
        end
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus and response outputs are registered images of the next state.
    cyc_d       = (state_d == REQ) || (state_d == WAIT);
    stb_d       = (state_d == REQ);
    rsp_valid_d = (state_d == RSP);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      retry_q      <= '0;
      tmo_q        <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign bus.cmd_ready_o  = (state_q == IDLE);
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_dat_o    = rsp_dat_q;
  assign bus.rsp_status_o = rsp_status_q;
  assign bus.wb_cyc_o     = cyc_q;
  assign bus.wb_stb_o     = stb_q;
  assign bus.wb_we_o      = we_q;
  assign bus.wb_adr_o     = adr_q;
  assign bus.wb_sel_o     = sel_q;
  assign bus.wb_dat_o     = dat_q;

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone pipelined initiator: turns single read/write commands from a local command port into one Wishbone classic-pipelined transaction each.
- Drives the slave side of generated register banks: cyc/stb/we/sel/dat, with stall/ack/err/rty returned from the slave.
- Handles stall back-pressure, error and retry responses, and a per-attempt timeout.
- Returns exactly one response (data plus status) per accepted command.

Parameters:
- ADDR_WIDTH, 32, width of cmd_adr_i and wb_adr_o.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- TIMEOUT, 255, number of cycles an attempt may spend in REQ+WAIT before it is aborted; range 1..65535.
- MAX_RETRY, 3, number of rty-induced re-issues allowed; 0 means no retry.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1=write, 0=read
- cmd_adr_i  in  ADDR_WIDTH  address
- cmd_dat_i  in  DATA_WIDTH  write data
- cmd_sel_i  in  DATA_WIDTH/8  byte selects
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_dat_o  out  DATA_WIDTH  read data (0 for writes and failures)
- rsp_status_o  out  2  00 ok, 01 err, 10 timeout, 11 retry exhausted
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone control
- wb_adr_o  out  ADDR_WIDTH;  wb_sel_o  out  DATA_WIDTH/8;  wb_dat_o  out  DATA_WIDTH
- wb_dat_i  in  DATA_WIDTH;  wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  1

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; all outputs 0 except cmd_ready_o=1.
  - Retry counter and timeout counter cleared.
  - Reset mid-transaction drops cyc/stb immediately and emits no response.
- FSM states: IDLE, REQ, WAIT, RSP. All outputs are registered except cmd_ready_o, which equals (state==IDLE).
- IDLE:
  - On cmd_valid_i&cmd_ready_o, latch we/adr/dat/sel onto the wb_* outputs, clear the retry counter, go to REQ.
  - wb_cyc_o=wb_stb_o=1 from the next cycle (one cycle command-to-strobe latency).
- REQ:
  - cyc=stb=1; address, data and sel held stable.
  - If wb_stall_i=0 the strobe is accepted this cycle. With no response in the same cycle: go to WAIT, stb=0 next cycle, cyc stays 1.
  - A response sampled in REQ while stall=0 (zero-wait slave) is handled as in WAIT.
  - A response in REQ while stall=1 is ignored.
- WAIT: cyc=1, stb=0. The first cycle with any of ack/err/rty resolves the attempt.
- Response priority when several strobes are asserted: err > rty > ack.
- Outcome per response:
  - ack: capture wb_dat_i when reading (0 when writing), status 00 → RSP.
  - err: status 01 → RSP.
  - rty with retry count < MAX_RETRY: increment count, go to REQ next cycle with cyc kept high, same address/data.
  - rty with retry count = MAX_RETRY: status 11 → RSP.
- Timeout:
  - The counter clears on every entry to REQ (each attempt) and increments every cycle in REQ or WAIT.
  - When the count reaches TIMEOUT with no response: status 10 → RSP.
  - A response arriving in the same cycle as expiry wins over the timeout.
- RSP:
  - cyc=stb=0; rsp_valid_o=1 for exactly this one cycle, with rsp_dat_o/rsp_status_o valid. No back-pressure on the response port.
  - Next state IDLE, so cmd_ready_o rises in the cycle after the rsp pulse; back-to-back commands therefore have at least one idle bus cycle between cycles.
- rsp_dat_o holds its value until the next RSP; rsp_status_o likewise.
- Responses arriving while cyc=0 (IDLE, RSP) are ignored.
- Single outstanding transaction; the block never issues a second strobe before resolving the first.

Test Plan:
1. Connect the generated single-register slave (one 32-bit r1, ack two cycles after strobe, stall=~ack&en). Write 0xDEADBEEF, sel=0xF → stb high 2 cycles, rsp_valid one cycle later with status 00. Then read → rsp_dat_o=0xDEADBEEF, status 00.
2. Model slave holds stall=1 for 5 cycles, then acks 3 cycles after acceptance for a read returning 0x12345678 → stb held 6 cycles with address stable, rsp_dat_o=0x12345678, status 00.
3. Slave asserts rty three times, then ack, with MAX_RETRY=3 → four strobes, status 00. Repeat with four rty → status 11, exactly four strobes issued.
4. Slave never responds, TIMEOUT=8 → rsp_valid exactly 8 cycles after the first stb, status 10, cyc low in the RSP cycle. Variant: ack in the expiry cycle → status 00.
5. Slave asserts err and ack together → status 01, rsp_dat_o=0. Assert rst_i mid-WAIT → cyc/stb go 0 immediately, no rsp_valid, cmd_ready_o=1.
6. cmd_valid_i held high with 4 queued writes → each accepted only in IDLE, exactly 4 rsp pulses, never two strobes outstanding.
